rv32i_multicycle_ctrl: RTL

//  Multi-cycle sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/rv32i_multicycle_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl
//   Multi-cycle sequencer for the RV32I core. Each instruction is stepped
//   through FETCH/DECODE/EXECUTE/MEM/WB. The block drives the PC/IR load
//   strobes, the datapath selects and the data-RAM handshake for the R, I,
//   IL (load), S and B instruction classes.
// Ports
//   iClk, iRst        clock; synchronous active-high reset
//   iInst_Code        IR contents, stable from DECODE until the next FETCH
//   iBranch_Taken     ALU compare result, sampled in EXECUTE of a branch
//   iMem_Ready        data RAM done (read data valid / write accepted)
//   oPC_En/oPCSrcSel  PC load strobe and source (0 = PC+4, 1 = PC+imm)
//   oIR_En            IR load strobe
//   oFunct3           iInst_Code[14:12] passthrough
//   oALU_Control      ALU opcode, decoded from the instruction
//   oALUSrcMuxSel     1 = immediate as ALU operand B
//   oRegWrDataSel     1 = regfile writeback from data RAM
//   oWrEn             regfile write strobe
//   oData_WrEn/RdEn   data RAM write / read requests
//   oInstr_Done       retire pulse
//   oIllegal          unsupported-opcode pulse
//   oBus_Err          MEM timeout pulse
//   oState            FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4
//   oRetire_Cnt       retired-instruction counter (wraps)
module rv32i_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [31:0]      iInst_Code,
   input  logic             iBranch_Taken,
   input  logic             iMem_Ready,
   output logic             oPC_En,
   output logic             oPCSrcSel,
   output logic             oIR_En,
   output logic [2:0]       oFunct3,
   output logic [3:0]       oALU_Control,
   output logic             oALUSrcMuxSel,
   output logic             oRegWrDataSel,
   output logic             oWrEn,
   output logic             oData_WrEn,
   output logic             oData_RdEn,
   output logic             oInstr_Done,
   output logic             oIllegal,
   output logic             oBus_Err,
   output logic [2:0]       oState,
   output logic [CNT_W-1:0] oRetire_Cnt
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t           r_state, w_next;
   logic [TW-1:0]    r_to_cnt;
   logic [CNT_W-1:0] r_retire_cnt;

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic       w_f7b;
   logic       w_is_r, w_is_i, w_is_il, w_is_s, w_is_b, w_legal;
   logic [3:0] w_alu;
   logic       w_pc_en, w_pcsrc, w_ir_en, w_alusrc, w_regwrsel, w_wren;
   logic       w_dwr, w_drd, w_done, w_ill, w_buserr;
   logic       w_unused;

   assign w_opc   = iInst_Code[6:0];
   assign w_f3    = iInst_Code[14:12];
   assign w_f7b   = iInst_Code[30];
   assign w_is_r  = (w_opc == 7'b0110011);
   assign w_is_i  = (w_opc == 7'b0010011);
   assign w_is_il = (w_opc == 7'b0000011);
   assign w_is_s  = (w_opc == 7'b0100011);
   assign w_is_b  = (w_opc == 7'b1100011);
   assign w_legal = w_is_r | w_is_i | w_is_il | w_is_s | w_is_b;
   assign w_unused = ^{iInst_Code[31], iInst_Code[29:15], iInst_Code[11:7]};

   // Only shift-immediates (f3=101) take f7[5] to pick SRLI vs SRAI.
   always_comb begin
      w_alu = 4'b0000;
      if (w_is_r)      w_alu = {w_f7b, w_f3};
      else if (w_is_i) w_alu = {(w_f3 == 3'b101) ? w_f7b : 1'b0, w_f3};
      else if (w_is_b) w_alu = {1'b0, w_f3};
   end

   always_comb begin
      w_next     = r_state;
      w_pc_en    = 1'b0;
      w_pcsrc    = 1'b0;
      w_ir_en    = 1'b0;
      w_alusrc   = 1'b0;
      w_regwrsel = 1'b0;
      w_wren     = 1'b0;
      w_dwr      = 1'b0;
      w_drd      = 1'b0;
      w_done     = 1'b0;
      w_ill      = 1'b0;
      w_buserr   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_en = 1'b1;
            w_next  = S_DECODE;
         end
         S_DECODE: begin
            if (w_legal) w_next = S_EXEC;
            else begin
               w_ill   = 1'b1;
               w_pc_en = 1'b1;
               w_next  = S_FETCH;
            end
         end
         S_EXEC: begin
            w_alusrc = w_is_i | w_is_il | w_is_s;
            if (w_is_b) begin
               w_pc_en = 1'b1;
               w_pcsrc = iBranch_Taken;
               w_done  = 1'b1;
               w_next  = S_FETCH;
            end else if (w_is_r | w_is_i) w_next = S_WB;
            else                          w_next = S_MEM;
         end
         S_MEM: begin
            w_drd = w_is_il;
            w_dwr = w_is_s;
            // Ready on the final timeout cycle still completes normally.
            if (iMem_Ready) begin
               if (w_is_il) w_next = S_WB;
               else begin
                  w_pc_en = 1'b1;
                  w_done  = 1'b1;
                  w_next  = S_FETCH;
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_buserr = 1'b1;
               w_pc_en  = 1'b1;
               w_next   = S_FETCH;
            end
         end
         S_WB: begin
            w_wren     = 1'b1;
            w_regwrsel = w_is_il;
            w_pc_en    = 1'b1;
            w_done     = 1'b1;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state      <= S_FETCH;
         r_to_cnt     <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_state      <= w_next;
         r_to_cnt     <= (r_state == S_MEM && w_next == S_MEM) ? r_to_cnt + TW'(1) : '0;
         if (w_done) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
   end

   // Reset masks every strobe combinationally so a pending data request
   // drops in the same cycle iRst rises.
   assign oPC_En        = w_pc_en    & ~iRst;
   assign oPCSrcSel     = w_pcsrc    & ~iRst;
   assign oIR_En        = w_ir_en    & ~iRst;
   assign oALUSrcMuxSel = w_alusrc   & ~iRst;
   assign oRegWrDataSel = w_regwrsel & ~iRst;
   assign oWrEn         = w_wren     & ~iRst;
   assign oData_WrEn    = w_dwr      & ~iRst;
   assign oData_RdEn    = w_drd      & ~iRst;
   assign oInstr_Done   = w_done     & ~iRst;
   assign oIllegal      = w_ill      & ~iRst;
   assign oBus_Err      = w_buserr   & ~iRst;
   assign oALU_Control  = iRst ? 4'b0000 : w_alu;
   assign oFunct3       = w_f3;
   assign oState        = r_state;
   assign oRetire_Cnt   = r_retire_cnt;

endmodule
